uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, PCLK frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, legal range 5..9, data bits per frame, LSB first.
REQ-004 SHALL have parameter PARITY_EN, default 0; when 1, one parity bit follows the data bits.
REQ-005 SHALL have parameter PARITY_ODD, default 0; 0 selects even parity, 1 selects odd parity.
REQ-006 SHALL have parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-007 SHALL have parameter OVERSAMPLE, default 16, samples per bit; the value is even and at least 8.
REQ-008 SHALL have parameter FIFO_DEPTH, default 8, number of entries; the value is a power of 2 and at least 2.
REQ-009 SHALL have ports:
- PCLK  in  1  sole clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- rx_en  in  1  receiver enable.
- rx_rst  in  1  synchronous flush of receiver and FIFO.
- rx_serial  in  1  asynchronous serial line; idles high.
- rd_en  in  1  pops the FIFO head.
- err_clr  in  1  clears the sticky overrun flag.
- rd_data  out  DATA_BITS  FIFO head data, first-word-fall-through.
- rd_perr  out  1  parity-error flag of the head entry.
- rd_ferr  out  1  framing-error flag of the head entry.
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- rx_busy  out  1  high while a frame is in progress.
- rx_done  out  1  one-cycle pulse when a frame is pushed.
- overrun  out  1  sticky; set when a frame is lost.

Function
REQ-010 SHALL pass rx_serial through a 2-flop synchronizer; all frame logic uses only the synchronized value.
REQ-011 SHALL generate a one-cycle sample tick every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) cycles, truncated (651 at the defaults); the divider runs only while rx_busy is high and restarts at 0 on start detection.
REQ-012 SHALL evaluate each bit as the 2-of-3 majority of ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within that bit.
REQ-013 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP and PUSH.
REQ-014 SHALL leave IDLE for START, setting rx_busy, only on a synchronized 1->0 transition while rx_en=1 and the line has been high since the last frame ended.
REQ-015 SHALL, in START, return to IDLE with no push when the majority value is 1 (false-start rejection); on a majority 0 it SHALL go to DATA.
REQ-016 SHALL, in DATA, shift in DATA_BITS bits LSB first, then go to PARITY if PARITY_EN=1, else to STOP.
REQ-017 SHALL, in PARITY, set the entry perr when the XOR of the data bits and the parity bit is not 0 (even parity) or not 1 (odd parity); perr SHALL be 0 when PARITY_EN=0.
REQ-018 SHALL, in STOP, sample STOP_BITS stop bits, set the entry ferr if any sampled stop bit is 0, and go to PUSH on the cycle after the last stop-bit majority decision.
REQ-019 SHALL, in PUSH (one cycle), write {data, perr, ferr} to the FIFO, pulse rx_done, clear rx_busy and return to IDLE.
REQ-020 SHALL, when ferr=1 (line possibly in break), not re-arm start detection until the synchronized line has been high.
REQ-021 SHALL, when a push occurs with the FIFO full and no simultaneous pop, discard the frame, suppress rx_done and set overrun.
REQ-022 SHALL, on a simultaneous pop and push at full, perform both, leaving fifo_count unchanged and overrun not set.
REQ-023 SHALL ignore rd_en while the FIFO is empty.
REQ-024 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-025 SHALL drive rd_data, rd_perr and rd_ferr from the head entry, valid while rd_valid=1.
REQ-026 SHALL keep overrun set until err_clr=1; an err_clr coinciding with a new overrun event SHALL leave overrun set.
REQ-027 SHALL, when rx_en=0 during a frame, abort the frame with no push and return to IDLE next cycle; the FIFO contents SHALL be kept.

Reset
REQ-028 SHALL, on PRESET=1 or rx_rst=1 at a PCLK edge, set the FSM to IDLE, clear the divider, bit counter, shift register and pointers, and drive rd_data=0, rd_perr=0, rd_ferr=0, rd_valid=0, fifo_count=0, rx_busy=0, rx_done=0, overrun=0.
REQ-029 SHALL initialize the synchronizer flops to 1.
REQ-030 SHALL give PRESET priority over all other inputs, including a reset asserted mid-frame.

Verification
REQ-031 Defaults, frames 0x16, 0x32, 0xAF at 10416 cycles/bit -> three rx_done pulses, FIFO pops 0x16, 0x32, 0xAF in order with perr=ferr=0.
REQ-032 PARITY_EN=1, even parity, 0x5A sent with parity bit 1 -> entry 0x5A with rd_perr=1, rd_ferr=0.
REQ-033 Frame 0x3C with stop bit 0, line then high -> entry 0x3C with rd_ferr=1; the next good frame 0x55 is received clean.
REQ-034 Low glitch of 3000 cycles on an idle line -> no push, rx_busy returns to 0, fifo_count stays 0.
REQ-035 FIFO_DEPTH=8, nine frames with no pops -> fifo_count=8, overrun=1, ninth frame absent; err_clr -> overrun=0; eight pops return frames 1..8.
REQ-036 PRESET pulse during the data bits of 0xA5 -> all outputs at their reset values next cycle; a following frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with majority-vote oversampling and a first-word-fall-through
// FIFO that stores each frame together with its parity/framing error flags.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic                          rx_en,
  input  logic                          rx_rst,
  input  logic                          rx_serial,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_perr,
  output logic                          rd_ferr,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy,
  output logic                          rx_done,
  output logic                          overrun
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH} state_t;

  state_t               state, state_n;
  logic                 flush;
  logic                 sync1, sync2, rx_prev;
  logic                 armed, start_det;
  logic [DIV_W-1:0]     div_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic                 tick, decide, s0, s1, maj;
  logic [DATA_BITS-1:0] shift;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt, stop_last;
  logic                 perr, ferr;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [EW-1:0]        head;
  logic                 push_req, push_ok, pop, full;

  assign flush = PRESET | rx_rst;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would make the synchronizer collapse to one flop.
  always_ff @(posedge PCLK) begin
    if (flush) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_serial;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign rx_busy   = (state != IDLE);
  assign start_det = (state == IDLE) && rx_en && armed && rx_prev && !sync2;

  assign tick   = rx_busy && (div_cnt == DIV_W'(DIV - 1));
  assign decide = tick && (os_cnt == OS_W'(OVERSAMPLE / 2 + 1));
  assign maj    = (s0 & s1) | (s0 & sync2) | (s1 & sync2);

  always_ff @(posedge PCLK) begin
    if (flush || !rx_busy) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      os_cnt  <= (os_cnt == OS_W'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign stop_last = (STOP_BITS == 1) || stop_cnt;

  always_ff @(posedge PCLK) begin
    if (flush) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (start_det) state_n = START;
      START:  if (decide) state_n = maj ? IDLE : DATA;
      DATA:   if (decide && bit_cnt == 4'(DATA_BITS - 1))
                state_n = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (decide) state_n = STOP;
      STOP:   if (decide && stop_last) state_n = PUSH;
      PUSH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!rx_en && state != IDLE && state != PUSH) state_n = IDLE;
  end

  always_ff @(posedge PCLK) begin
    if (flush) begin
      s0       <= 1'b1;
      s1       <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      armed    <= 1'b1;
    end else begin
      // After a framing error the line may sit in break; wait for it to go high.
      if (state == PUSH && ferr && !sync2) armed <= 1'b0;
      else if (sync2)                      armed <= 1'b1;
      if (tick && os_cnt == OS_W'(OVERSAMPLE / 2 - 1)) s0 <= sync2;
      if (tick && os_cnt == OS_W'(OVERSAMPLE / 2))     s1 <= sync2;
      if (start_det) begin
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        perr     <= 1'b0;
        ferr     <= 1'b0;
      end else if (decide) begin
        case (state)
          DATA: begin
            shift   <= {maj, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY: perr <= (^{shift, maj}) ^ (PARITY_ODD != 0);
          STOP: begin
            ferr     <= ferr | ~maj;
            stop_cnt <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign push_req = (state == PUSH);
  assign full     = (fifo_count == (AW + 1)'(FIFO_DEPTH));
  assign pop      = rd_en && (fifo_count != '0);
  assign push_ok  = push_req && (!full || pop);

  always_ff @(posedge PCLK) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (!push_ok && pop) fifo_count <= fifo_count - 1'b1;
      if (push_req && full && !pop) overrun <= 1'b1;
      else if (err_clr)             overrun <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; outputs are masked by rd_valid
  // instead, which keeps the array as plain RAM.
  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wr_ptr] <= {shift, perr, ferr};
  end

  assign head     = mem[rd_ptr];
  assign rd_valid = (fifo_count != '0);
  assign rd_data  = rd_valid ? head[EW-1:2] : '0;
  assign rd_perr  = rd_valid & head[1];
  assign rd_ferr  = rd_valid & head[0];
  assign rx_done  = push_ok;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a scaled bit period (160 clocks) keeps
// frames short; a second instance exercises even parity.
module tb_uart_rx_fifo;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       PRESET, rx_en, rx_rst, err_clr;
  logic       rx_serial, rd_en, rx_serial_p, rd_en_p;
  logic [7:0] rd_data, rd_data_p;
  logic       rd_perr, rd_ferr, rd_valid, rx_busy, rx_done, overrun;
  logic       rd_perr_p, rd_ferr_p, rd_valid_p, rx_busy_p, rx_done_p, overrun_p;
  logic [3:0] fifo_count, fifo_count_p;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int done_p = 0;
  int d0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000)) dut (
    .PCLK(clk), .PRESET(PRESET), .rx_en(rx_en), .rx_rst(rx_rst),
    .rx_serial(rx_serial), .rd_en(rd_en), .err_clr(err_clr),
    .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr),
    .rd_valid(rd_valid), .fifo_count(fifo_count), .rx_busy(rx_busy),
    .rx_done(rx_done), .overrun(overrun)
  );

  uart_rx_fifo #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .PARITY_EN(1)) dut_p (
    .PCLK(clk), .PRESET(PRESET), .rx_en(rx_en), .rx_rst(rx_rst),
    .rx_serial(rx_serial_p), .rd_en(rd_en_p), .err_clr(err_clr),
    .rd_data(rd_data_p), .rd_perr(rd_perr_p), .rd_ferr(rd_ferr_p),
    .rd_valid(rd_valid_p), .fifo_count(fifo_count_p), .rx_busy(rx_busy_p),
    .rx_done(rx_done_p), .overrun(overrun_p)
  );

  always @(posedge clk) begin
    if (rx_done)   done_cnt++;
    if (rx_done_p) done_p++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives bits LSB first, one bit period each, then idles the line for two bits.
  task automatic send(input logic [15:0] bits, input int n, input bit to_p);
    for (int i = 0; i < n; i++) begin
      if (to_p) rx_serial_p = bits[i];
      else      rx_serial   = bits[i];
      tick(BIT);
    end
    if (to_p) rx_serial_p = 1'b1;
    else      rx_serial   = 1'b1;
    tick(2 * BIT);
  endtask

  task automatic send_byte(input logic [7:0] d);
    send({6'b0, 1'b1, d, 1'b0}, 10, 1'b0);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] d, input logic pe, input logic fe);
    check({tag, ".valid"}, rd_valid, 1);
    check({tag, ".data"},  rd_data, d);
    check({tag, ".perr"},  rd_perr, pe);
    check({tag, ".ferr"},  rd_ferr, fe);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1; rx_en = 1'b1; rx_rst = 1'b0; err_clr = 1'b0;
    rx_serial = 1'b1; rx_serial_p = 1'b1; rd_en = 1'b0; rd_en_p = 1'b0;
    tick(3);
    PRESET = 1'b0;
    tick(2);

    // Reset state
    check("rst.valid", rd_valid, 0);
    check("rst.count", fifo_count, 0);
    check("rst.busy",  rx_busy, 0);
    check("rst.ovr",   overrun, 0);
    check("rst.data",  rd_data, 0);
    check("rst.done",  rx_done, 0);

    // Three back-to-back clean frames
    send_byte(8'h16);
    send_byte(8'h32);
    send_byte(8'hAF);
    check("f3.done",  done_cnt, 3);
    check("f3.count", fifo_count, 3);
    pop_check("f3.0", 8'h16, 0, 0);
    pop_check("f3.1", 8'h32, 0, 0);
    pop_check("f3.2", 8'hAF, 0, 0);
    check("f3.empty", rd_valid, 0);

    // Pop while empty is ignored
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    check("empty_pop.count", fifo_count, 0);

    // Even parity: 0x5A has four ones, so parity 1 is wrong; 0x5B with 1 is right
    send({5'b0, 1'b1, 1'b1, 8'h5A, 1'b0}, 11, 1'b1);
    send({5'b0, 1'b1, 1'b1, 8'h5B, 1'b0}, 11, 1'b1);
    check("par.done",  done_p, 2);
    check("par.data0", rd_data_p, 8'h5A);
    check("par.perr0", rd_perr_p, 1);
    check("par.ferr0", rd_ferr_p, 0);
    rd_en_p = 1'b1; tick(1); rd_en_p = 1'b0;
    check("par.data1", rd_data_p, 8'h5B);
    check("par.perr1", rd_perr_p, 0);
    rd_en_p = 1'b1; tick(1); rd_en_p = 1'b0;
    check("par.empty", rd_valid_p, 0);

    // Framing error followed by a clean frame
    send({6'b0, 1'b0, 8'h3C, 1'b0}, 10, 1'b0);
    send_byte(8'h55);
    check("ferr.count", fifo_count, 2);
    pop_check("ferr.0", 8'h3C, 0, 1);
    pop_check("ferr.1", 8'h55, 0, 0);

    // Short low glitch is rejected as a false start
    d0 = done_cnt;
    rx_serial = 1'b0;
    tick(20);
    check("glitch.busy_hi", rx_busy, 1);
    tick(26);
    rx_serial = 1'b1;
    tick(2 * BIT);
    check("glitch.busy_lo", rx_busy, 0);
    check("glitch.count", fifo_count, 0);
    check("glitch.done", done_cnt, d0);

    // Nine frames into an eight-entry FIFO: ninth lost, overrun set
    d0 = done_cnt;
    for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i));
    check("ovr.count", fifo_count, 8);
    check("ovr.flag",  overrun, 1);
    check("ovr.done",  done_cnt, d0 + 8);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    check("ovr.clr", overrun, 0);
    for (int i = 0; i < 8; i++) pop_check($sformatf("ovr.pop%0d", i), 8'h10 + 8'(i), 0, 0);
    check("ovr.empty", rd_valid, 0);

    // rx_en dropped mid-frame aborts without a push
    d0 = done_cnt;
    rx_serial = 1'b0; tick(BIT);
    rx_serial = 1'b1; tick(BIT);
    rx_serial = 1'b0; tick(BIT);
    rx_en = 1'b0;
    tick(2);
    check("abort.busy", rx_busy, 0);
    rx_serial = 1'b1;
    tick(BIT);
    rx_en = 1'b1;
    tick(BIT);
    check("abort.count", fifo_count, 0);
    check("abort.done",  done_cnt, d0);

    // PRESET mid-frame clears everything, then a new frame is received
    send_byte(8'h99);
    check("prst.pre_count", fifo_count, 1);
    rx_serial = 1'b0; tick(BIT);
    rx_serial = 1'b1; tick(BIT);
    rx_serial = 1'b0; tick(BIT);
    rx_serial = 1'b1; tick(40);
    check("prst.pre_busy", rx_busy, 1);
    PRESET = 1'b1;
    tick(1);
    PRESET = 1'b0;
    check("prst.busy",  rx_busy, 0);
    check("prst.count", fifo_count, 0);
    check("prst.valid", rd_valid, 0);
    check("prst.data",  rd_data, 0);
    check("prst.ferr",  rd_ferr, 0);
    check("prst.done",  rx_done, 0);
    check("prst.ovr",   overrun, 0);
    tick(2 * BIT);
    d0 = done_cnt;
    send_byte(8'h81);
    check("prst.after_done", done_cnt, d0 + 1);
    pop_check("prst.after", 8'h81, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
